// File: rtl/pipe_ctl.sv
// pipe_ctl: voice-activity driven staged power-up / drain controller.
// Ports: clk_i, rst_i (async active-high) | vad_i voice activity, wake_valid_i
// inference result valid, force_on_i hold in ACTIVE | en_o staged enables
// (bit 0 first), state_o state encoding, timeout_o one-cycle DRAIN timeout pulse.
module pipe_ctl #(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int NUM_STAGES      = 3,
   parameter int STAGGER_CYCLES  = 2,
   parameter int HOLD_CYCLES     = 12,
   parameter int TIMEOUT_CYCLES  = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  vad_i,
   input  logic                  wake_valid_i,
   input  logic                  force_on_i,
   output logic [NUM_STAGES-1:0] en_o,
   output logic [2:0]            state_o,
   output logic                  timeout_o
);
   localparam int RAMP_MAX = (NUM_STAGES - 1) * STAGGER_CYCLES;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   // a single-stage pipeline has no ramp span, but the counter still needs a bit
   localparam int RW = RAMP_MAX > 0 ? $clog2(RAMP_MAX + 1) : 1;
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_MAX);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DEBOUNCE = 3'd1,
      RAMP     = 3'd2,
      ACTIVE   = 3'd3,
      DRAIN    = 3'd4
   } state_t;
   state_t state, state_n;
   logic [DW-1:0] deb_cnt, deb_n;
   logic [RW-1:0] ramp_cnt, ramp_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [TW-1:0] to_cnt, to_n;
   logic wake_valid_q, timeout_n, fall;
   assign fall = wake_valid_q & ~wake_valid_i;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         deb_cnt      <= '0;
         ramp_cnt     <= '0;
         hold_cnt     <= '0;
         to_cnt       <= '0;
         wake_valid_q <= 1'b0;
         timeout_o    <= 1'b0;
      end else begin
         state        <= state_n;
         deb_cnt      <= deb_n;
         ramp_cnt     <= ramp_n;
         hold_cnt     <= hold_n;
         to_cnt       <= to_n;
         wake_valid_q <= wake_valid_i;
         timeout_o    <= timeout_n;
      end
   end
   // counters default to zero so every state entry starts them cleared;
   // a counter only advances while its own state persists
   always_comb begin
      state_n   = state;
      deb_n     = '0;
      ramp_n    = '0;
      hold_n    = '0;
      to_n      = '0;
      timeout_n = 1'b0;
      case (state)
         IDLE: begin
            if (vad_i) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_n = RAMP;
               end else begin
                  state_n = DEBOUNCE;
                  deb_n   = DW'(1);
               end
            end
         end
         DEBOUNCE: begin
            if (!vad_i)                  state_n = IDLE;
            else if (deb_cnt == DEB_LAST) state_n = RAMP;
            else                          deb_n   = deb_cnt + 1'b1;
         end
         RAMP: begin
            if (ramp_cnt == RAMP_LAST) state_n = ACTIVE;
            else                       ramp_n  = ramp_cnt + 1'b1;
         end
         ACTIVE: begin
            if (vad_i || force_on_i)        hold_n  = '0;
            else if (hold_cnt == HOLD_LAST) state_n = DRAIN;
            else                            hold_n  = hold_cnt + 1'b1;
         end
         DRAIN: begin
            // activity beats result completion, which beats timeout
            if (vad_i || force_on_i) begin
               state_n = ACTIVE;
            end else if (fall) begin
               state_n = IDLE;
            end else if (to_cnt == TO_LAST) begin
               state_n   = IDLE;
               timeout_n = 1'b1;
            end else begin
               to_n = to_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_en
      assign en_o[k] = (state == ACTIVE) || (state == DRAIN) ||
                       ((state == RAMP) && (ramp_cnt >= RW'(k * STAGGER_CYCLES)));
   end
   assign state_o = state;
endmodule

// File: doc/pipe_ctl.md
PIPE_CTL -- requirements
Module: pipe_ctl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset (clk_i, rst_i).
REQ-002 Parameter DEBOUNCE_CYCLES, default 2, SHALL be the number of consecutive vad_i-high cycles (>=1) that triggers wake-up.
REQ-003 Parameter NUM_STAGES, default 3, SHALL be the number of staged enable outputs (>=1).
REQ-004 Parameter STAGGER_CYCLES, default 2, SHALL be the cycle spacing between successive stage enables (>=1).
REQ-005 Parameter HOLD_CYCLES, default 12, SHALL be the number of vad_i-low cycles tolerated in ACTIVE before DRAIN (>=1).
REQ-006 Parameter TIMEOUT_CYCLES, default 64, SHALL be the maximum DRAIN dwell, in cycles, without a wake_valid_i falling edge (>=1).
REQ-007 The port clk_i SHALL be an input of width 1 carrying the system clock.
REQ-008 The port rst_i SHALL be an input of width 1 carrying the asynchronous active-high reset.
REQ-009 The port vad_i SHALL be an input of width 1 carrying the voice-activity flag.
REQ-010 The port wake_valid_i SHALL be an input of width 1 that is high while an inference result is valid.
REQ-011 The port force_on_i SHALL be an input of width 1 that, when high, holds the pipeline in ACTIVE.
REQ-012 The port en_o SHALL be an output of width NUM_STAGES carrying the per-stage enables, with bit 0 enabled first.
REQ-013 The port state_o SHALL be an output of width 3 carrying the current state encoding.
REQ-014 The port timeout_o SHALL be an output of width 1 carrying a one-cycle pulse on DRAIN timeout.

Function
REQ-015 The state encoding SHALL be IDLE=0, DEBOUNCE=1, RAMP=2, ACTIVE=3, DRAIN=4; any other value SHALL return to IDLE on the next edge.
REQ-016 In IDLE, vad_i=1 SHALL load deb_cnt=1 and enter DEBOUNCE, or enter RAMP directly if DEBOUNCE_CYCLES==1.
REQ-017 In DEBOUNCE, vad_i=0 SHALL return to IDLE, and vad_i=1 with deb_cnt==DEBOUNCE_CYCLES-1 SHALL enter RAMP; otherwise deb_cnt SHALL increment.
REQ-018 On RAMP entry ramp_cnt SHALL be 0, and it SHALL increment each cycle.
REQ-019 RAMP SHALL move to ACTIVE on the edge where ramp_cnt==(NUM_STAGES-1)*STAGGER_CYCLES.
REQ-020 en_o[k] SHALL be combinational: 1 iff state is ACTIVE or DRAIN, or state is RAMP with ramp_cnt >= k*STAGGER_CYCLES; en_o SHALL be 0 in IDLE and DEBOUNCE.
REQ-021 On ACTIVE entry hold_cnt SHALL be 0.
REQ-022 In ACTIVE, vad_i=1 or force_on_i=1 SHALL clear hold_cnt, and otherwise hold_cnt SHALL increment.
REQ-023 ACTIVE SHALL enter DRAIN on the edge where hold_cnt==HOLD_CYCLES with vad_i=0 and force_on_i=0.
REQ-024 A register wake_valid_q SHALL track wake_valid_i in every state, and fall = wake_valid_q & ~wake_valid_i.
REQ-025 In DRAIN, vad_i=1 or force_on_i=1 SHALL return to ACTIVE with hold_cnt=0, with priority over fall and timeout.
REQ-026 In DRAIN, fall=1 SHALL return to IDLE, clearing all en_o on the same edge.
REQ-027 On DRAIN entry to_cnt SHALL be 0, and it SHALL increment each cycle; to_cnt==TIMEOUT_CYCLES-1 without fall SHALL return to IDLE and register timeout_o=1 for exactly one cycle.
REQ-028 If fall and timeout occur in the same cycle, fall SHALL win and timeout_o SHALL stay 0.
REQ-029 vad_i SHALL be ignored in RAMP.
REQ-030 Each counter SHALL be $clog2(max+1) bits wide, SHALL never wrap, and SHALL be cleared on every state entry.

Reset
REQ-031 Asserting rst_i SHALL, without a clock edge, force state=IDLE, all counters=0, wake_valid_q=0, timeout_o=0 and en_o=0, including mid-RAMP or mid-DRAIN.
REQ-032 After rst_i deasserts, the first IDLE evaluation SHALL occur on the next clk_i rising edge.

Verification
REQ-033 vad_i high for 1 cycle -> state_o goes 1 then 0; en_o stays 000.
REQ-034 vad_i high at edges 0 and 1 -> RAMP after edge 1 with en_o=001; 011 after edge 3; 111 after edge 5; ACTIVE after edge 6.
REQ-035 In ACTIVE, vad_i low continuously -> DRAIN after 13 edges; a single vad_i pulse at hold_cnt=8 restarts the count.
REQ-036 In DRAIN, wake_valid_i 1 then 0 -> IDLE on the edge after the fall, en_o=000; vad_i=1 in DRAIN instead -> ACTIVE.
REQ-037 In DRAIN, wake_valid_i held 0 -> IDLE after 64 edges with timeout_o high for exactly 1 cycle.
REQ-038 rst_i pulsed asynchronously mid-RAMP (en_o=011) -> en_o=000 and state_o=0 before the next clk_i edge.
